// File: rtl/riscv_ex_stage_if.sv
// Bundle between the ID/EX register, the execute stage and the EX/MEM register.
// The pipeline control (master) drives ID/EX state and forwarding; the EX stage (slave) returns EX/MEM.
interface riscv_ex_stage_if #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    logic                     valid_id2ex_ff;
    logic [3:0]               alu_op_id2ex_ff;
    logic                     alu_src_imm_id2ex_ff;
    logic [XLEN-1:0]          rs1_data_id2ex_ff;
    logic [XLEN-1:0]          rs2_data_id2ex_ff;
    logic [XLEN-1:0]          imm_id2ex_ff;
    logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff;
    logic                     reg_write_id2ex_ff;
    logic [1:0]               fwd_a;
    logic [1:0]               fwd_b;
    logic [XLEN-1:0]          wb_data_mem2wb;
    logic                     flush_ex;

    logic                     ex_busy;
    logic                     valid_ex2mem_ff;
    logic [XLEN-1:0]          alu_result_ex2mem_ff;
    logic [XLEN-1:0]          store_data_ex2mem_ff;
    logic [RF_ADDR_WIDTH-1:0] rd_ex2mem_ff;
    logic                     reg_write_ex2mem_ff;

    modport master (
        output valid_id2ex_ff, alu_op_id2ex_ff, alu_src_imm_id2ex_ff,
               rs1_data_id2ex_ff, rs2_data_id2ex_ff, imm_id2ex_ff,
               rd_id2ex_ff, reg_write_id2ex_ff, fwd_a, fwd_b,
               wb_data_mem2wb, flush_ex,
        input  ex_busy, valid_ex2mem_ff, alu_result_ex2mem_ff,
               store_data_ex2mem_ff, rd_ex2mem_ff, reg_write_ex2mem_ff
    );

    modport slave (
        input  valid_id2ex_ff, alu_op_id2ex_ff, alu_src_imm_id2ex_ff,
               rs1_data_id2ex_ff, rs2_data_id2ex_ff, imm_id2ex_ff,
               rd_id2ex_ff, reg_write_id2ex_ff, fwd_a, fwd_b,
               wb_data_mem2wb, flush_ex,
        output ex_busy, valid_ex2mem_ff, alu_result_ex2mem_ff,
               store_data_ex2mem_ff, rd_ex2mem_ff, reg_write_ex2mem_ff
    );
endinterface

// File: rtl/riscv_ex_stage.sv
// Execute stage with EX/MEM pipeline register: forwarding operand mux, single-cycle ALU
// and an iterative shift-add multiplier that stalls the front of the pipe while it runs.
module riscv_ex_stage #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input logic             clk,
    input logic             rst_n,
    riscv_ex_stage_if.slave bus
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    state_e                   state_q;
    logic [SHAMT_W-1:0]       cnt_q;
    logic [XLEN-1:0]          mul_a_q;
    logic [XLEN-1:0]          mul_b_q;
    logic [XLEN-1:0]          acc_q;
    logic [RF_ADDR_WIDTH-1:0] mul_rd_q;
    logic                     mul_rw_q;

    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          rs2_fwd;
    logic [XLEN-1:0]          operand_b;
    logic [SHAMT_W-1:0]       shamt;
    logic [XLEN-1:0]          alu_result;
    logic [XLEN-1:0]          mul_partial;
    logic [XLEN-1:0]          acc_next;
    logic                     start_mul;

    // 2'b11 is unused by the forwarding unit and falls back to register-file data.
    function automatic logic [XLEN-1:0] fwd_select(input logic [1:0]      code,
                                                   input logic [XLEN-1:0] rf_data,
                                                   input logic [XLEN-1:0] ex_data,
                                                   input logic [XLEN-1:0] wb_data);
        case (code)
            2'b10:   return ex_data;
            2'b01:   return wb_data;
            default: return rf_data;
        endcase
    endfunction

    always_comb begin
        operand_a = fwd_select(bus.fwd_a, bus.rs1_data_id2ex_ff,
                               bus.alu_result_ex2mem_ff, bus.wb_data_mem2wb);
        rs2_fwd   = fwd_select(bus.fwd_b, bus.rs2_data_id2ex_ff,
                               bus.alu_result_ex2mem_ff, bus.wb_data_mem2wb);
        operand_b = bus.alu_src_imm_id2ex_ff ? bus.imm_id2ex_ff : rs2_fwd;
        shamt     = operand_b[SHAMT_W-1:0];
    end

    always_comb begin
        // NOTE: default first so every path assigns alu_result and no latch is inferred.
        alu_result = '0;
        case (alu_op_e'(bus.alu_op_id2ex_ff))
            OP_ADD:  alu_result = operand_a + operand_b;
            OP_SUB:  alu_result = operand_a - operand_b;
            OP_AND:  alu_result = operand_a & operand_b;
            OP_OR:   alu_result = operand_a | operand_b;
            OP_XOR:  alu_result = operand_a ^ operand_b;
            OP_SLL:  alu_result = operand_a << shamt;
            OP_SRL:  alu_result = operand_a >> shamt;
            OP_SRA:  alu_result = XLEN'($signed(operand_a) >>> shamt);
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            default: alu_result = '0;
        endcase
    end

    // Bit cnt_q of the latched multiplier selects A<<cnt_q; the last step (cnt_q==0) is folded
    // into the value written to EX/MEM so the product leaves on the same edge it completes.
    assign mul_partial = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;
    assign acc_next    = acc_q + mul_partial;

    assign start_mul = bus.valid_id2ex_ff && (bus.alu_op_id2ex_ff == OP_MUL);

    assign bus.ex_busy = bus.flush_ex         ? 1'b0 :
                         (state_q == ST_IDLE) ? start_mul :
                                                (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                  <= ST_IDLE;
            cnt_q                    <= '0;
            mul_a_q                  <= '0;
            mul_b_q                  <= '0;
            acc_q                    <= '0;
            mul_rd_q                 <= '0;
            mul_rw_q                 <= 1'b0;
            bus.valid_ex2mem_ff      <= 1'b0;
            bus.alu_result_ex2mem_ff <= '0;
            bus.store_data_ex2mem_ff <= '0;
            bus.rd_ex2mem_ff         <= '0;
            bus.reg_write_ex2mem_ff  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; the bubble below is the default and a later
            // assignment in the same edge overrides it.
            bus.valid_ex2mem_ff      <= 1'b0;
            bus.alu_result_ex2mem_ff <= '0;
            bus.store_data_ex2mem_ff <= '0;
            bus.rd_ex2mem_ff         <= '0;
            bus.reg_write_ex2mem_ff  <= 1'b0;

            if (bus.flush_ex) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_mul) begin
                            mul_a_q  <= operand_a;
                            mul_b_q  <= operand_b;
                            mul_rd_q <= bus.rd_id2ex_ff;
                            mul_rw_q <= bus.reg_write_id2ex_ff;
                            acc_q    <= '0;
                            cnt_q    <= SHAMT_W'(XLEN - 1);
                            state_q  <= ST_MUL;
                        end else if (bus.valid_id2ex_ff) begin
                            bus.valid_ex2mem_ff      <= 1'b1;
                            bus.alu_result_ex2mem_ff <= alu_result;
                            bus.store_data_ex2mem_ff <= rs2_fwd;
                            bus.rd_ex2mem_ff         <= bus.rd_id2ex_ff;
                            bus.reg_write_ex2mem_ff  <= bus.reg_write_id2ex_ff;
                        end
                    end
                    ST_MUL: begin
                        acc_q <= acc_next;
                        if (cnt_q == '0) begin
                            bus.valid_ex2mem_ff      <= 1'b1;
                            bus.alu_result_ex2mem_ff <= acc_next;
                            bus.rd_ex2mem_ff         <= mul_rd_q;
                            bus.reg_write_ex2mem_ff  <= mul_rw_q;
                            state_q                  <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
